// File: rtl/ws2812_pkg.sv
// WS2812 line timing shared by the transmitter and receiver, expressed in
// 100 MHz clock cycles, plus the receiver's decoder state encoding.
package ws2812_pkg;

  localparam int WS_CLK_MHZ      = 100;
  localparam int WS_T0H          = 40;
  localparam int WS_T1H          = 80;
  localparam int WS_T_BIT        = 125;
  localparam int WS_LATCH_CYCLES = 5000;
  localparam int WS_BITS_PER_PIXEL = 24;

  // Receive thresholds: a glitch is well under T0H, the 0/1 split sits midway
  // between T0H and T1H, and anything past T0H+T1H is a stuck line.
  localparam int WS_MIN_HIGH    = (WS_T0H * 3) / 8;
  localparam int WS_THRESH_HIGH = (WS_T0H + WS_T1H) / 2;
  localparam int WS_MAX_HIGH    = WS_T0H + WS_T1H;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Synchronizes the raw WS2812 line, flags its edges and measures the length
// of the current high and low runs in clock cycles.
module ws2812_pulse_meter
  import ws2812_pkg::*;
#(
  parameter int MAX_HIGH     = WS_MAX_HIGH,
  parameter int LATCH_CYCLES = WS_LATCH_CYCLES,
  localparam int HCNT_W      = $clog2(MAX_HIGH + 2),
  localparam int LCNT_W      = $clog2(LATCH_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic              rise,
  output logic              fall,
  output logic [HCNT_W-1:0] hcnt,
  output logic [LCNT_W-1:0] lcnt
);

  localparam logic [HCNT_W-1:0] HCNT_SAT = HCNT_W'(MAX_HIGH + 1);
  localparam logic [LCNT_W-1:0] LCNT_SAT = LCNT_W'(LATCH_CYCLES);

  logic sync_q;
  logic din_s;
  logic din_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      din_s  <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      sync_q <= din;
      din_s  <= sync_q;
      din_d  <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // Each counter holds the length of the run ending in the previous cycle, so
  // on the falling-edge cycle hcnt is exactly the number of high cycles seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      if (!din_s)
        hcnt <= '0;
      else if (hcnt != HCNT_SAT)
        hcnt <= hcnt + HCNT_W'(1);

      if (din_s)
        lcnt <= '0;
      else if (lcnt != LCNT_SAT)
        lcnt <= lcnt + LCNT_W'(1);
    end
  end

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 receiver: decodes pulse widths into pixel words, tracks pixel index
// within a frame, and reports frame latches, overflow and protocol errors.
module neopixel_rx
  import ws2812_pkg::*;
#(
  parameter int BITS_PER_PIXEL = WS_BITS_PER_PIXEL,
  parameter int PX_COUNT_WIDTH = 6,
  parameter int MAX_PIXELS     = 52,
  parameter int MIN_HIGH       = WS_MIN_HIGH,
  parameter int THRESH_HIGH    = WS_THRESH_HIGH,
  parameter int MAX_HIGH       = WS_MAX_HIGH,
  parameter int LATCH_CYCLES   = WS_LATCH_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel_out,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] pixel_idx,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
  output logic                      bit_error,
  output logic                      px_overflow
);

  localparam int HCNT_W = $clog2(MAX_HIGH + 2);
  localparam int LCNT_W = $clog2(LATCH_CYCLES + 1);
  localparam int BCNT_W = $clog2(BITS_PER_PIXEL);

  localparam logic [HCNT_W-1:0]         H_MIN   = HCNT_W'(MIN_HIGH);
  localparam logic [HCNT_W-1:0]         H_THR   = HCNT_W'(THRESH_HIGH);
  localparam logic [HCNT_W-1:0]         H_MAX   = HCNT_W'(MAX_HIGH);
  localparam logic [LCNT_W-1:0]         L_LATCH = LCNT_W'(LATCH_CYCLES);
  localparam logic [BCNT_W-1:0]         B_LAST  = BCNT_W'(BITS_PER_PIXEL - 1);
  localparam logic [PX_COUNT_WIDTH-1:0] PX_MAX  = PX_COUNT_WIDTH'(MAX_PIXELS);

  logic              rise;
  logic              fall;
  logic [HCNT_W-1:0] hcnt;
  logic [LCNT_W-1:0] lcnt;

  ws2812_pulse_meter #(
    .MAX_HIGH     (MAX_HIGH),
    .LATCH_CYCLES (LATCH_CYCLES)
  ) u_meter (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rise  (rise),
    .fall  (fall),
    .hcnt  (hcnt),
    .lcnt  (lcnt)
  );

  rx_state_t                 state;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BITS_PER_PIXEL-1:0] shreg_next;
  logic [BCNT_W-1:0]         bitcnt;
  logic [PX_COUNT_WIDTH-1:0] pxcnt;
  logic                      latch_hit;
  logic                      glitch;

  assign shreg_next = {shreg[BITS_PER_PIXEL-2:0], (hcnt >= H_THR)};
  assign latch_hit  = (lcnt == L_LATCH);
  assign glitch     = (hcnt > H_MAX) || (fall && (hcnt < H_MIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SYNC;
      shreg          <= '0;
      bitcnt         <= '0;
      pxcnt          <= '0;
      pixel_out      <= '0;
      pixel_idx      <= '0;
      frame_px_count <= '0;
      pixel_valid    <= 1'b0;
      frame_done     <= 1'b0;
      bit_error      <= 1'b0;
      px_overflow    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      px_overflow <= 1'b0;

      case (state)
        // Nothing is trusted until the line has been low for a full latch gap.
        SYNC: begin
          shreg  <= '0;
          bitcnt <= '0;
          pxcnt  <= '0;
          if (latch_hit)
            state <= rise ? HIGH : IDLE;
        end

        IDLE: begin
          if (rise)
            state <= HIGH;
        end

        HIGH: begin
          if (glitch) begin
            bit_error <= 1'b1;
            shreg     <= '0;
            bitcnt    <= '0;
            state     <= SYNC;
          end else if (fall) begin
            state <= LOW;
            if (bitcnt == B_LAST) begin
              bitcnt <= '0;
              shreg  <= '0;
              if (pxcnt < PX_MAX) begin
                pixel_out   <= shreg_next;
                pixel_idx   <= pxcnt;
                pixel_valid <= 1'b1;
                pxcnt       <= pxcnt + PX_COUNT_WIDTH'(1);
              end else begin
                px_overflow <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + BCNT_W'(1);
              shreg  <= shreg_next;
            end
          end
        end

        LOW: begin
          // A latch with a partial word pending is a truncated pixel.
          if (latch_hit) begin
            frame_done     <= 1'b1;
            frame_px_count <= pxcnt;
            bit_error      <= (bitcnt != '0);
            pxcnt          <= '0;
            bitcnt         <= '0;
            shreg          <= '0;
            state          <= rise ? HIGH : IDLE;
          end else if (rise) begin
            state <= HIGH;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule
